// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block instruction cache.
// Hits are answered combinationally in IDLE. A miss latches the word
// address and runs a single-outstanding fill in FETCH until iwait drops.
module icache #(
   parameter int INDEX_BITS = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hitcount,
   output logic [31:0] misscount
);

   localparam int SETS  = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t                state_q, state_d;
   logic [31:0]           missaddr_q, missaddr_d;
   logic [31:0]           hitcount_q, hitcount_d;
   logic [31:0]           misscount_q, misscount_d;
   logic [SETS-1:0]       valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q  [SETS];
   logic [31:0]           data_q [SETS];

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0]      req_tag, fill_tag;
   logic                  lookup_hit;
   logic                  fill_we;

   assign req_idx    = imemaddr[INDEX_BITS+1:2];
   assign req_tag    = imemaddr[31:INDEX_BITS+2];
   assign fill_idx   = missaddr_q[INDEX_BITS+1:2];
   assign fill_tag   = missaddr_q[31:INDEX_BITS+2];
   assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

   assign hitcount  = hitcount_q;
   assign misscount = misscount_q;

   // Next-state, fill control, counters and datapath-facing outputs.
   always_comb begin
      state_d     = state_q;
      missaddr_d  = missaddr_q;
      hitcount_d  = hitcount_q;
      misscount_d = misscount_q;
      valid_d     = valid_q;
      fill_we     = 1'b0;
      ihit        = 1'b0;
      imemload    = 32'd0;
      iREN        = 1'b0;
      iaddr       = missaddr_q;
      case (state_q)
         IDLE: begin
            ihit = lookup_hit;
            if (lookup_hit) imemload = data_q[req_idx];
            if (imemREN && !lookup_hit) begin
               // byte offset is dropped so iaddr is always word aligned
               missaddr_d = imemaddr & ~32'h3;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            // fill uses the latched address even if the request moved on
            iREN = 1'b1;
            if (!iwait) begin
               fill_we           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               misscount_d       = misscount_q + 32'd1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (ihit) hitcount_d = hitcount_q + 32'd1;
   end

   // Control state, valid bits and counters; reset drops any in-flight fill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         missaddr_q  <= 32'd0;
         hitcount_q  <= 32'd0;
         misscount_q <= 32'd0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         missaddr_q  <= missaddr_d;
         hitcount_q  <= hitcount_d;
         misscount_q <= misscount_d;
         valid_q     <= valid_d;
      end
   end

   // Tag and data arrays carry no reset; valid bits qualify them.
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed per-cycle vectors; the stimulus process pushes the
// expected outputs of each cycle into a queue, and a monitor on the falling
// edge pops and compares them against the DUT.
module tb_icache;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        imemREN = 1'b0;
   logic [31:0] imemaddr = 32'd0;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait = 1'b1;
   logic [31:0] iload = 32'd0;
   logic [31:0] hitcount;
   logic [31:0] misscount;

   icache #(.INDEX_BITS(4)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .hitcount(hitcount), .misscount(misscount)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          cyc;
      string       name;
      logic        ihit;
      logic [31:0] load;
      logic        iren;
      logic [31:0] iaddr;
      logic [31:0] hc;
      logic [31:0] mc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   bit   stim_done = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
   endtask

   // Monitor: compares every queued expectation belonging to this cycle.
   always @(negedge CLK) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.cyc != cyc) begin
            total++;
            $display("FAIL %s.skipped actual_cycle=%0d required_cycle=%0d", e.name, cyc, e.cyc);
         end else begin
            chk(e.name, "ihit",      {31'd0, ihit}, {31'd0, e.ihit});
            chk(e.name, "imemload",  imemload,      e.load);
            chk(e.name, "iREN",      {31'd0, iREN}, {31'd0, e.iren});
            chk(e.name, "iaddr",     iaddr,         e.iaddr);
            chk(e.name, "hitcount",  hitcount,      e.hc);
            chk(e.name, "misscount", misscount,     e.mc);
         end
      end
   end

   // One cycle: drive inputs just after the rising edge, queue expectations.
   task automatic step(input logic rst_n, input logic ren, input logic [31:0] addr,
                       input logic wt, input logic [31:0] ld, input string nm,
                       input logic eh, input logic [31:0] el, input logic er,
                       input logic [31:0] ea, input logic [31:0] ehc,
                       input logic [31:0] emc);
      exp_t e;
      @(posedge CLK);
      #1;
      nRST     = rst_n;
      imemREN  = ren;
      imemaddr = addr;
      iwait    = wt;
      iload    = ld;
      e.cyc = cyc; e.name = nm; e.ihit = eh; e.load = el; e.iren = er;
      e.iaddr = ea; e.hc = ehc; e.mc = emc;
      exp_q.push_back(e);
   endtask

   initial begin
      // reset state
      step(0, 0, 32'h0, 1, 32'h0, "reset", 0, 32'h0, 0, 32'h0, 0, 0);
      // cold miss, W=2
      step(1, 1, 32'h40, 1, 32'h0,        "cold0", 0, 32'h0, 0, 32'h00, 0, 0);
      step(1, 1, 32'h40, 1, 32'h0,        "cold1", 0, 32'h0, 1, 32'h40, 0, 0);
      step(1, 1, 32'h40, 1, 32'h0,        "cold2", 0, 32'h0, 1, 32'h40, 0, 0);
      step(1, 1, 32'h40, 0, 32'h8C010004, "cold3", 0, 32'h0, 1, 32'h40, 0, 0);
      step(1, 1, 32'h40, 1, 32'h0,        "cold4", 1, 32'h8C010004, 0, 32'h40, 0, 1);
      // hit streak
      for (int i = 1; i <= 5; i++)
         step(1, 1, 32'h40, 1, 32'h0, $sformatf("streak%0d", i), 1, 32'h8C010004, 0,
              32'h40, i, 1);
      // conflict eviction, from a fresh reset
      step(0, 0, 32'h0,  1, 32'h0,        "rst2",  0, 32'h0, 0, 32'h00, 0, 0);
      step(1, 1, 32'h04, 1, 32'h0,        "cf0",   0, 32'h0, 0, 32'h00, 0, 0);
      step(1, 1, 32'h04, 0, 32'hAAAA0004, "cf1",   0, 32'h0, 1, 32'h04, 0, 0);
      step(1, 1, 32'h04, 1, 32'h0,        "cf2",   1, 32'hAAAA0004, 0, 32'h04, 0, 1);
      step(1, 1, 32'h44, 1, 32'h0,        "cf3",   0, 32'h0, 0, 32'h04, 1, 1);
      step(1, 1, 32'h44, 0, 32'hBBBB0044, "cf4",   0, 32'h0, 1, 32'h44, 1, 1);
      step(1, 1, 32'h44, 1, 32'h0,        "cf5",   1, 32'hBBBB0044, 0, 32'h44, 1, 2);
      step(1, 1, 32'h04, 1, 32'h0,        "cf6",   0, 32'h0, 0, 32'h44, 2, 2);
      step(1, 1, 32'h04, 0, 32'hAAAA0004, "cf7",   0, 32'h0, 1, 32'h04, 2, 2);
      step(1, 1, 32'h04, 1, 32'h0,        "cf8",   1, 32'hAAAA0004, 0, 32'h04, 2, 3);
      // address change mid-fill
      step(1, 1, 32'h08, 1, 32'h0,        "mid0",  0, 32'h0, 0, 32'h04, 3, 3);
      step(1, 0, 32'h0C, 1, 32'h0,        "mid1",  0, 32'h0, 1, 32'h08, 3, 3);
      step(1, 0, 32'h0C, 0, 32'hCCCC0008, "mid2",  0, 32'h0, 1, 32'h08, 3, 3);
      step(1, 1, 32'h0C, 1, 32'h0,        "mid3",  0, 32'h0, 0, 32'h08, 3, 4);
      step(1, 1, 32'h0C, 0, 32'hDDDD000C, "mid4",  0, 32'h0, 1, 32'h0C, 3, 4);
      step(1, 1, 32'h0C, 1, 32'h0,        "mid5",  1, 32'hDDDD000C, 0, 32'h0C, 3, 5);
      step(1, 1, 32'h08, 1, 32'h0,        "mid6",  1, 32'hCCCC0008, 0, 32'h0C, 4, 5);
      // byte offset ignored
      step(1, 1, 32'h10, 1, 32'h0,        "byte0", 0, 32'h0, 0, 32'h0C, 5, 5);
      step(1, 1, 32'h10, 0, 32'hEEEE0010, "byte1", 0, 32'h0, 1, 32'h10, 5, 5);
      step(1, 1, 32'h10, 1, 32'h0,        "byte2", 1, 32'hEEEE0010, 0, 32'h10, 5, 6);
      step(1, 1, 32'h13, 1, 32'h0,        "byte3", 1, 32'hEEEE0010, 0, 32'h10, 6, 6);
      // reset mid-fill
      step(1, 1, 32'h20, 1, 32'h0,        "rmf0",  0, 32'h0, 0, 32'h10, 7, 6);
      step(1, 1, 32'h20, 1, 32'h0,        "rmf1",  0, 32'h0, 1, 32'h20, 7, 6);
      step(0, 1, 32'h20, 0, 32'h55550020, "rmf2",  0, 32'h0, 0, 32'h00, 0, 0);
      step(1, 1, 32'h20, 1, 32'h0,        "rmf3",  0, 32'h0, 0, 32'h00, 0, 0);
      step(1, 1, 32'h20, 0, 32'h12340020, "rmf4",  0, 32'h0, 1, 32'h20, 0, 0);
      step(1, 1, 32'h20, 1, 32'h0,        "rmf5",  1, 32'h12340020, 0, 32'h20, 0, 1);
      step(1, 1, 32'h10, 1, 32'h0,        "rmf6",  0, 32'h0, 0, 32'h20, 1, 1);
      step(1, 0, 32'h10, 0, 32'h0,        "rmf7",  0, 32'h0, 1, 32'h10, 1, 1);
      step(1, 0, 32'h10, 1, 32'h0,        "rmf8",  0, 32'h0, 0, 32'h10, 1, 2);
      stim_done = 1'b1;
   end

   // Drain the scoreboard with a bounded wait, then report.
   initial begin
      wait (stim_done);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
      #1;
      if (exp_q.size() > 0) begin
         total++;
         $display("FAIL drain actual_left=%0d required_left=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
